// File: rtl/sysid_check_ctrl.sv
// System-ID check sequencer: reads the ID and build timestamp words from the
// shared ID slave, compares them against expected values, and arbitrates host reads.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5452_32CA,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sid_read,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        host_read,
  input  logic        host_address,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        check_valid,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHK_ID = 3'd1,
    CHK_TS = 3'd2,
    CMP    = 3'd3,
    HOST   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  lat_cnt_r;
  logic        lat_last_s;
  logic        go_check_s;
  logic        pending_r;
  logic        host_addr_r;
  logic [31:0] id_value_r;
  logic [31:0] ts_value_r;
  logic [31:0] host_readdata_r;
  logic        host_rvalid_r;
  logic        id_ok_r;
  logic        ts_ok_r;
  logic        done_r;
  logic        check_valid_r;
  logic        sid_read_s;
  logic        sid_address_s;
  logic        host_wait_s;

  assign lat_last_s = (lat_cnt_r == LAT_LAST);
  assign go_check_s = pending_r | start;

  // State register and per-access cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      lat_cnt_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == CHK_ID || state_r == CHK_TS || state_r == HOST) && !lat_last_s) begin
        lat_cnt_r <= lat_cnt_r + 4'd1;
      end else begin
        lat_cnt_r <= 4'd0;
      end
    end
  end

  // Next-state arbitration and slave/host handshake decode
  always_comb begin
    state_s       = state_r;
    sid_read_s    = 1'b0;
    sid_address_s = 1'b0;
    host_wait_s   = 1'b1;
    case (state_r)
      IDLE: begin
        // A check request always wins over a simultaneous host read
        if (go_check_s) begin
          state_s = CHK_ID;
        end else if (host_read) begin
          state_s = HOST;
        end else begin
          state_s = IDLE;
        end
      end
      CHK_ID: begin
        sid_read_s = 1'b1;
        if (lat_last_s) begin
          state_s = CHK_TS;
        end else begin
          state_s = CHK_ID;
        end
      end
      CHK_TS: begin
        sid_read_s    = 1'b1;
        sid_address_s = 1'b1;
        if (lat_last_s) begin
          state_s = CMP;
        end else begin
          state_s = CHK_TS;
        end
      end
      CMP: begin
        state_s = IDLE;
      end
      HOST: begin
        sid_read_s    = 1'b1;
        sid_address_s = host_addr_r;
        host_wait_s   = ~lat_last_s;
        if (lat_last_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pending request, captured words, compare results and host read return
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r       <= AUTO_START;
      host_addr_r     <= 1'b0;
      id_value_r      <= 32'h0000_0000;
      ts_value_r      <= 32'h0000_0000;
      host_readdata_r <= 32'h0000_0000;
      host_rvalid_r   <= 1'b0;
      id_ok_r         <= 1'b0;
      ts_ok_r         <= 1'b0;
      done_r          <= 1'b0;
      check_valid_r   <= 1'b0;
    end else begin
      // Leaving IDLE consumes any request; elsewhere further starts merge
      if (state_r == IDLE) begin
        pending_r <= 1'b0;
      end else if (start) begin
        pending_r <= 1'b1;
      end
      if (state_r == IDLE && !go_check_s && host_read) begin
        host_addr_r <= host_address;
      end
      if (state_r == CHK_ID && lat_last_s) begin
        id_value_r <= sid_readdata;
      end
      if (state_r == CHK_TS && lat_last_s) begin
        ts_value_r <= sid_readdata;
      end
      if (state_r == CMP) begin
        id_ok_r       <= (id_value_r == EXPECTED_ID);
        ts_ok_r       <= (ts_value_r == EXPECTED_TS);
        check_valid_r <= 1'b1;
      end
      done_r <= (state_r == CMP);
      if (state_r == HOST && lat_last_s) begin
        host_readdata_r <= sid_readdata;
      end
      host_rvalid_r <= (state_r == HOST) && lat_last_s;
    end
  end

  assign sid_read           = sid_read_s;
  assign sid_address        = sid_address_s;
  assign host_waitrequest   = host_wait_s;
  assign host_readdata      = host_readdata_r;
  assign host_readdatavalid = host_rvalid_r;
  assign busy               = (state_r == CHK_ID) || (state_r == CHK_TS) || (state_r == CMP) || done_r;
  assign done               = done_r;
  assign check_valid        = check_valid_r;
  assign id_value           = id_value_r;
  assign ts_value           = ts_value_r;
  assign id_ok              = id_ok_r;
  assign ts_ok              = ts_ok_r;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (read latency 1 and 3) sharing a
// behavioural ID slave, checked against timing and data rules of the check/host protocol.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5452_32CA;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic        host_read [2];
  logic        host_address [2];
  logic [31:0] mem [2];

  wire         sid_read [2];
  wire         sid_address [2];
  wire  [31:0] sid_readdata [2];
  wire         host_wait [2];
  wire  [31:0] host_rdata [2];
  wire         host_rvalid [2];
  wire         busy [2];
  wire         done [2];
  wire         check_valid [2];
  wire  [31:0] id_value [2];
  wire  [31:0] ts_value [2];
  wire         id_ok [2];
  wire         ts_ok [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign sid_readdata[g] = sid_read[g] ? mem[sid_address[g]] : 32'hDEAD_BEEF;
    sysid_check_ctrl #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
      .READ_LATENCY(g == 0 ? 1 : 3), .AUTO_START(1'b1)
    ) u_dut (
      .clock(clk), .reset(reset), .start(start[g]),
      .sid_read(sid_read[g]), .sid_address(sid_address[g]), .sid_readdata(sid_readdata[g]),
      .host_read(host_read[g]), .host_address(host_address[g]),
      .host_waitrequest(host_wait[g]), .host_readdata(host_rdata[g]),
      .host_readdatavalid(host_rvalid[g]), .busy(busy[g]), .done(done[g]),
      .check_valid(check_valid[g]), .id_value(id_value[g]), .ts_value(ts_value[g]),
      .id_ok(id_ok[g]), .ts_ok(ts_ok[g])
    );
  end

  function automatic int lat(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start, follow the slave bus each cycle until done; n = cycle done is seen.
  task automatic run_check(input int s, output int n);
    int trace[$];
    int expq[$];
    int mism;
    int busy_cnt;
    start[s] = 1'b1;
    tick;
    start[s] = 1'b0;
    n = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      if (n == 0) begin
        trace.push_back(sid_read[s] ? int'(sid_address[s]) : 2);
        if (busy[s]) busy_cnt++;
        if (done[s]) n = c;
        else tick;
      end
    end
    if (n == 0) check_eq("done_timeout", 32'd0, 32'd1);
    for (int i = 0; i < lat(s); i++) expq.push_back(0);
    for (int i = 0; i < lat(s); i++) expq.push_back(1);
    expq.push_back(2);
    expq.push_back(2);
    mism = (trace.size() == expq.size()) ? 0 : 100;
    for (int i = 0; i < trace.size() && i < expq.size(); i++)
      if (trace[i] != expq[i]) mism++;
    check_eq("sid_trace", 32'(mism), 32'd0);
    check_eq("busy_cycles", 32'(busy_cnt), 32'(n));
    check_eq("done_latency", 32'(n), 32'(2 * lat(s) + 2));
    tick;
    check_eq("done_pulse_end", {31'd0, done[s]}, 32'd0);
    check_eq("busy_after", {31'd0, busy[s]}, 32'd0);
  endtask

  // Host read with the hold-until-accepted protocol; wc = cycle waitrequest is low.
  task automatic host_txn(input int s, input logic a, output logic [31:0] d, output int wc,
                          output logic vok);
    host_read[s] = 1'b1;
    host_address[s] = a;
    tick;
    wc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (wc == 0) begin
        if (!host_wait[s]) wc = c;
        else tick;
      end
    end
    if (wc == 0) check_eq("host_accept_timeout", 32'd0, 32'd1);
    tick;
    host_read[s] = 1'b0;
    vok = host_rvalid[s];
    d = host_rdata[s];
    tick;
    check_eq("host_rvalid_pulse_end", {31'd0, host_rvalid[s]}, 32'd0);
  endtask

  initial begin
    int n, wc, dc, vc, viol, dones;
    int addrs[$];
    logic [31:0] d, rd, cap_id, cap_ts;
    logic vok, a;

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      host_read[s] = 1'b0;
      host_address[s] = 1'b0;
    end
    mem[0] = EXP_ID;
    mem[1] = EXP_TS;
    tick;
    tick;
    check_eq("rst_busy", {31'd0, busy[0]}, 32'd0);
    check_eq("rst_sid_read", {31'd0, sid_read[0]}, 32'd0);
    check_eq("rst_waitreq", {31'd0, host_wait[0]}, 32'd1);
    check_eq("rst_check_valid", {31'd0, check_valid[0]}, 32'd0);
    check_eq("rst_id_value", id_value[0], 32'd0);
    check_eq("rst_done", {31'd0, done[0]}, 32'd0);

    // Auto-start after reset release
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (sid_read[0]) addrs.push_back(int'(sid_address[0]));
      if (done[0]) dones++;
    end
    check_eq("auto_addr_count", 32'(addrs.size()), 32'd2);
    if (addrs.size() == 2) begin
      check_eq("auto_addr0", 32'(addrs[0]), 32'd0);
      check_eq("auto_addr1", 32'(addrs[1]), 32'd1);
    end
    check_eq("auto_done_count", 32'(dones), 32'd1);
    check_eq("auto_id_ok", {31'd0, id_ok[0]}, 32'd1);
    check_eq("auto_ts_ok", {31'd0, ts_ok[0]}, 32'd1);
    check_eq("auto_check_valid", {31'd0, check_valid[0]}, 32'd1);
    check_eq("auto_busy", {31'd0, busy[0]}, 32'd0);

    // Wrong ID word
    mem[0] = 32'h0000_0001;
    run_check(0, n);
    check_eq("badid_id_ok", {31'd0, id_ok[0]}, 32'd0);
    check_eq("badid_ts_ok", {31'd0, ts_ok[0]}, 32'd1);
    check_eq("badid_id_value", id_value[0], 32'h0000_0001);

    // Latency 3 instance
    mem[0] = EXP_ID;
    run_check(1, n);
    check_eq("lat3_id_ok", {31'd0, id_ok[1]}, 32'd1);

    // Host read, latency 1; captured ID must not move
    cap_id = id_value[0];
    host_txn(0, 1'b1, d, wc, vok);
    check_eq("host_wait_cycle", 32'(wc), 32'd1);
    check_eq("host_valid", {31'd0, vok}, 32'd1);
    check_eq("host_data", d, EXP_TS);
    check_eq("host_keeps_id", id_value[0], cap_id);

    // start and host_read in the same IDLE cycle: check first, then host
    start[0] = 1'b1;
    host_read[0] = 1'b1;
    host_address[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    dc = 0; wc = 0; vc = 0; viol = 0; rd = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      if (done[0] && dc == 0) dc = c;
      if (host_rvalid[0] && vc == 0) begin
        vc = c;
        rd = host_rdata[0];
      end
      if (!host_wait[0] && wc == 0) wc = c;
      if (!host_wait[0] && busy[0]) viol++;
      tick;
      if (wc != 0) host_read[0] = 1'b0;
    end
    check_eq("arb_done_cycle", 32'(dc), 32'd4);
    check_eq("arb_accept_cycle", 32'(wc), 32'd5);
    check_eq("arb_valid_cycle", 32'(vc), 32'd6);
    check_eq("arb_data", rd, EXP_TS);
    check_eq("arb_wait_during_check", 32'(viol), 32'd0);

    // Two starts during a latency-3 host access merge into one check
    mem[0] = $urandom;
    host_read[1] = 1'b1;
    host_address[1] = 1'b0;
    tick;
    start[1] = 1'b1;
    tick;
    tick;
    start[1] = 1'b0;
    check_eq("merge_wait_low", {31'd0, host_wait[1]}, 32'd0);
    tick;
    host_read[1] = 1'b0;
    check_eq("merge_host_valid", {31'd0, host_rvalid[1]}, 32'd1);
    check_eq("merge_host_data", host_rdata[1], mem[0]);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (done[1]) dones++;
    end
    check_eq("merge_done_count", 32'(dones), 32'd1);
    check_eq("merge_id_value", id_value[1], mem[0]);

    // Randomized checks and host reads against the slave contents
    for (int it = 0; it < 8; it++) begin
      int s;
      s = int'($urandom_range(0, 1));
      mem[0] = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      mem[1] = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      cap_id = mem[0];
      cap_ts = mem[1];
      run_check(s, n);
      check_eq("rnd_id_value", id_value[s], cap_id);
      check_eq("rnd_ts_value", ts_value[s], cap_ts);
      check_eq("rnd_id_ok", {31'd0, id_ok[s]}, {31'd0, cap_id == EXP_ID});
      check_eq("rnd_ts_ok", {31'd0, ts_ok[s]}, {31'd0, cap_ts == EXP_TS});
      check_eq("rnd_check_valid", {31'd0, check_valid[s]}, 32'd1);
      a = 1'($urandom_range(0, 1));
      mem[a] = $urandom;
      host_txn(s, a, d, wc, vok);
      check_eq("rnd_host_wait_cycle", 32'(wc), 32'(lat(s)));
      check_eq("rnd_host_valid", {31'd0, vok}, 32'd1);
      check_eq("rnd_host_data", d, mem[a]);
      check_eq("rnd_host_keeps_id", id_value[s], cap_id);
      check_eq("rnd_host_keeps_ts", ts_value[s], cap_ts);
    end

    // Reset during CHK_TS aborts the access and clears results
    mem[0] = EXP_ID;
    mem[1] = EXP_TS;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    tick;
    check_eq("mid_in_chk_ts", {30'd0, sid_read[0], sid_address[0]}, 32'd3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("mid_sid_read", {31'd0, sid_read[0]}, 32'd0);
    check_eq("mid_check_valid", {31'd0, check_valid[0]}, 32'd0);
    check_eq("mid_id_value", id_value[0], 32'd0);
    check_eq("mid_done", {31'd0, done[0]}, 32'd0);
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (done[0]) dones++;
    end
    check_eq("mid_auto_done_count", 32'(dones), 32'd1);
    check_eq("mid_auto_check_valid", {31'd0, check_valid[0]}, 32'd1);
    check_eq("mid_auto_ts_ok", {31'd0, ts_ok[0]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Sequencer and arbiter in front of the single system-ID slave (32-bit word at address 0 = system ID, address 1 = build timestamp).
- After reset, or on request, it reads both words, registers them, compares them against build-time expected values and reports pass/fail to boot/status logic.
- Between checks it shares the same slave with one host read requester (Avalon-MM style); the checker always wins ties.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0.
- EXPECTED_TS, 32'h5452_32CA (1414673098), expected word at address 1.
- READ_LATENCY, 1, cycles sid_read is held per access (legal 1..15); data sampled at the edge ending the last cycle.
- AUTO_START, 1, when 1 a check is pending as reset releases.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle check request
- sid_read  out  1  read strobe to the ID slave
- sid_address  out  1  word select to the ID slave
- sid_readdata  in  32  ID slave read data (combinational source)
- host_read  in  1  host read request, held until accepted
- host_address  in  1  host word select
- host_waitrequest  out  1  high = host access not accepted this cycle
- host_readdata  out  32  registered host read data
- host_readdatavalid  out  1  one-cycle pulse qualifying host_readdata
- busy  out  1  check sequence in progress
- done  out  1  one-cycle pulse when a check completes
- check_valid  out  1  sticky; high once any check has completed since reset
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word
- id_ok  out  1  id_value == EXPECTED_ID
- ts_ok  out  1  ts_value == EXPECTED_TS

Behaviour:
- Reset, when sampled high: state IDLE; all outputs 0 except host_waitrequest = 1. The one-deep pending flag is set to AUTO_START.
- Reset asserted mid-access: the access is aborted; sid_read is low in the cycle after the reset edge; captured values and check_valid are cleared; no done or host_readdatavalid pulse.
- States: IDLE, CHK_ID, CHK_TS, CMP, HOST.
- IDLE, arbitration order:
  - pending or start -> CHK_ID; clear pending.
  - else host_read -> HOST, latching host_address.
  - A check request always beats a simultaneous host_read.
- CHK_ID:
  - sid_read = 1, sid_address = 0 for READ_LATENCY cycles.
  - id_value is captured at the final edge, then -> CHK_TS.
- CHK_TS: same as CHK_ID with sid_address = 1, capturing ts_value, then -> CMP.
- CMP, one cycle: register id_ok and ts_ok; done = 1 and check_valid = 1 in the following cycle; -> IDLE.
- Check timing: start sampled in IDLE at edge 0 -> done high in cycle 2*READ_LATENCY + 2 (cycle 4 for latency 1).
- busy: high in CHK_ID, CHK_TS and CMP, and in the done cycle.
- start while busy or in HOST: sets pending (one deep; further starts merge). The check runs on the next return to IDLE.
- HOST:
  - sid_read = 1 with the latched address for READ_LATENCY cycles.
  - host_waitrequest = 0 only in the final cycle of the access; it is 1 in every other cycle.
  - The next cycle registers host_readdata and pulses host_readdatavalid; -> IDLE.
  - The host must hold host_read and host_address until waitrequest is low.
- sid_read is never high in IDLE; only one owner drives the slave at a time; back-to-back accesses have no idle gap.
- Captured values and ok flags hold until the next completed check or reset. Host reads do not modify them.

Test Plan:
- Reset with AUTO_START=1, READ_LATENCY=1, slave returning 0 / 1414673098 -> addresses 0 then 1 driven; done pulses once; id_ok = ts_ok = 1; check_valid = 1; busy low afterwards.
- Slave returns 0x0000_0001 at address 0 -> id_ok = 0, ts_ok = 1, id_value = 1.
- READ_LATENCY=3: start pulse -> sid_read high for 6 consecutive cycles (3 at address 0, 3 at address 1); done exactly 8 cycles after start sampled.
- host_read at address 1 in IDLE, latency 1 -> host_waitrequest low in the access cycle; next cycle host_readdatavalid = 1 with host_readdata = 1414673098.
- start and host_read in the same IDLE cycle -> check runs first with host_waitrequest held high throughout; host read completes immediately after; two starts during the host access yield exactly one additional check.
- Reset pulsed during CHK_TS -> sid_read low the next cycle; check_valid, id_value and done are 0; with AUTO_START=1 a fresh check completes afterwards.
